pcie_tx_fc_credit_gate: RTL and testbench
=========================================

// Module: pcie_tx_fc_credit_gate
// PURPOSE
//  Transmit-side flow-control credit gate for VC0 in the PCIe Data Link Layer.
//  Sits between the transaction-layer TLP source and the DLL framing/sequence stage.
//  Consumes decoded FC DLLPs (InitFC1/InitFC2/UpdateFC) from the DLLP receive parser.
//  Runs the FC init state machine and admits a TLP only when the link partner
//  has advertised enough header and data credits for its class.
// PARAMETERS
//  HDR_FC_W   8   header credit field width (modulo 2^8 arithmetic)
//  DATA_FC_W  12  data credit field width (modulo 2^12; 1 credit = 16B)
//  VC_ID      0   VC accepted from fc_dllp_type_i[2:0]; DLLPs for other VCs are ignored
// PORTS
//  sclk                  in   1          clock
//  sreset                in   1          synchronous reset, active-high
//  link_up_i             in   1          DL_Up from LTSSM; 0 forces FC_IDLE
//  fc_dllp_valid_i       in   1          one decoded, CRC-good FC DLLP this cycle
//  fc_dllp_type_i        in   8          DLLP type byte (0x40/50/60 InitFC1 P/NP/Cpl; 0xC0/D0/E0 InitFC2; 0x80/90/A0 UpdateFC)
//  fc_dllp_hdr_i         in   HDR_FC_W   HdrFC field
//  fc_dllp_data_i        in   DATA_FC_W  DataFC field
//  tlp_req_valid_i       in   1          TLP pending at head of TX queue
//  tlp_req_class_i       in   2          0 Posted, 1 NonPosted, 2 Completion, 3 reserved
//  tlp_req_data_cred_i   in   DATA_FC_W  data credits needed (ceil(payload_B/16); 0 if no payload)
//  tlp_req_ready_o       out  1          TLP may be issued; transfer = valid & ready
//  fc_state_o            out  2          0 FC_IDLE, 1 FC_INIT1, 2 FC_INIT2, 3 FC_ACTIVE
//  fc_init_done_o        out  1          1 in FC_ACTIVE
//  fc_err_o              out  1          1-cycle pulse: class-3 request or data-credit overflow
// BEHAVIOUR
//  Reset: state FC_IDLE; all CREDIT_LIMIT and CREDITS_CONSUMED regs 0; infinite flags 0; all outputs 0.
//  Per class c in {P,NP,Cpl}: CL_H[c], CL_D[c] (limit), CC_H[c], CC_D[c] (consumed), INF_H[c], INF_D[c].
//  FSM (state registered):
//   FC_IDLE  -> FC_INIT1 when link_up_i=1.
//   FC_INIT1: InitFC1 for class c loads CL_H/CL_D; field==0 sets INF_*; duplicates overwrite.
//     Leaves for FC_INIT2 on the cycle after all three classes have been recorded.
//   FC_INIT2: InitFC1 ignored; first InitFC2 or UpdateFC (any class) -> FC_ACTIVE.
//   FC_ACTIVE: UpdateFC for class c loads CL_H/CL_D unless the matching INF_* is set (then ignored).
//     InitFC1/InitFC2 ignored.
//   Any state: link_up_i=0 -> FC_IDLE next cycle; clear all limits, consumed counts and flags.
//  Credit check (combinational from registered values; ready has zero latency from valid):
//   req_h = 1, req_d = tlp_req_data_cred_i.
//   ok_h = INF_H | ((CL_H - (CC_H + req_h)) mod 2^HDR_FC_W  <= 2^(HDR_FC_W-1)).
//   ok_d = INF_D | req_d==0 | ((CL_D - (CC_D + req_d)) mod 2^DATA_FC_W <= 2^(DATA_FC_W-1)).
//   tlp_req_ready_o = (state==FC_ACTIVE) & class!=3 & ok_h & ok_d.
//  On transfer: CC_H[c] += 1, CC_D[c] += req_d, both mod 2^width; visible next cycle.
//  Back-to-back grants each see the prior cycle's consumed update. No bypass is needed.
//  Strict head-of-line: no reordering across classes. An ungranted request stalls.
//  Simultaneous UpdateFC and grant on the same class: both register updates apply in that cycle.
//   The grant decision uses the old limit.
//  UpdateFC whose limit is behind CC is stored as-is. The modular check then blocks issue.
//  fc_err_o pulses when valid & class==3 (never ready).
//  fc_err_o pulses when req_d > 2^(DATA_FC_W-1) (never ready).
// TESTING
//  T1 init: link_up; InitFC1 P/NP/Cpl hdr=4,data=16; InitFC2 -> fc_state_o 1,2,3; fc_init_done_o=1.
//  T2 exhaust: limits P hdr=4,data=16; four P TLPs data_cred=4 granted -> 5th ready=0.
//    UpdateFC P hdr=5,data=20 -> 5th granted next cycle.
//  T3 infinite: InitFC1 Cpl hdr=0,data=0 -> 300 Cpl TLPs (data_cred=8) all ready.
//    UpdateFC Cpl ignored.
//  T4 wrap: CC_H=250, CL_H=3 (wrapped) -> 9 more grants, 10th blocked.
//    Same test with data at 4090/4 for the 12-bit data counter.
//  T5 simultaneous: UpdateFC NP and NP grant on same cycle -> CC_NP_H +1 and CL_NP_H updated.
//    Next request uses both.
//  T6 link drop mid-stream: link_up_i=0 during ACTIVE -> state 0, ready=0 next cycle.
//    Re-init restarts with CC=0.

Source files
------------

// File: rtl/pcie_tx_fc_credit_gate_if.sv
// Bundles the signals between the TLP source/DLLP parser and the VC0 TX credit gate.
// Handshake: a TLP moves when tlp_req_valid_i and tlp_req_ready_o are both high on a
// rising sclk edge. The source holds valid, class and data_cred stable until that edge.
// ready may depend on the current request fields but never on valid itself.
// fc_dllp_valid_i is a one-cycle strobe with no back-pressure.
interface pcie_tx_fc_credit_gate_if #(
  parameter int HDR_FC_W  = 8,
  parameter int DATA_FC_W = 12
);
  logic                 fc_dllp_valid_i;
  logic [7:0]           fc_dllp_type_i;
  logic [HDR_FC_W-1:0]  fc_dllp_hdr_i;
  logic [DATA_FC_W-1:0] fc_dllp_data_i;
  logic                 tlp_req_valid_i;
  logic [1:0]           tlp_req_class_i;
  logic [DATA_FC_W-1:0] tlp_req_data_cred_i;
  logic                 tlp_req_ready_o;
  logic [1:0]           fc_state_o;
  logic                 fc_init_done_o;
  logic                 fc_err_o;

  // Upstream side: DLLP parser plus TLP source.
  modport master (
    output fc_dllp_valid_i, fc_dllp_type_i, fc_dllp_hdr_i, fc_dllp_data_i,
    output tlp_req_valid_i, tlp_req_class_i, tlp_req_data_cred_i,
    input  tlp_req_ready_o, fc_state_o, fc_init_done_o, fc_err_o
  );

  // Credit gate side.
  modport slave (
    input  fc_dllp_valid_i, fc_dllp_type_i, fc_dllp_hdr_i, fc_dllp_data_i,
    input  tlp_req_valid_i, tlp_req_class_i, tlp_req_data_cred_i,
    output tlp_req_ready_o, fc_state_o, fc_init_done_o, fc_err_o
  );
endinterface

// File: rtl/pcie_tx_fc_credit_gate.sv
// Transmit-side flow-control credit gate for a single VC.
// It runs the FC init sequence from decoded FC DLLPs and tracks the advertised limits and the
// consumed credits per class (P, NP, Cpl). It admits the head TLP only if both header and data
// credits fit, using the modular (wrapping) comparison that PCIe flow control requires.
module pcie_tx_fc_credit_gate #(
  parameter int HDR_FC_W  = 8,
  parameter int DATA_FC_W = 12,
  parameter int VC_ID     = 0
) (
  input  logic sclk,
  input  logic sreset,
  input  logic link_up_i,
  pcie_tx_fc_credit_gate_if.slave bus
);

  typedef enum logic [1:0] {
    FC_IDLE   = 2'd0,
    FC_INIT1  = 2'd1,
    FC_INIT2  = 2'd2,
    FC_ACTIVE = 2'd3
  } fc_state_t;

  localparam logic [2:0]           VC_SEL    = VC_ID[2:0];
  localparam logic [HDR_FC_W-1:0]  HDR_ONE   = HDR_FC_W'(1);
  localparam logic [HDR_FC_W-1:0]  HDR_HALF  = {1'b1, {(HDR_FC_W-1){1'b0}}};
  localparam logic [DATA_FC_W-1:0] DATA_HALF = {1'b1, {(DATA_FC_W-1){1'b0}}};

  fc_state_t            state;
  logic                 init_done_q;
  logic                 err_q;
  logic [2:0]           seen;
  logic [2:0]           inf_h;
  logic [2:0]           inf_d;
  logic [HDR_FC_W-1:0]  cl_h [0:2];
  logic [HDR_FC_W-1:0]  cc_h [0:2];
  logic [DATA_FC_W-1:0] cl_d [0:2];
  logic [DATA_FC_W-1:0] cc_d [0:2];

  // DLLP decode: type[7:6] is the kind (01 InitFC1, 11 InitFC2, 10 UpdateFC),
  // type[5:4] is the class, type[3] must be 0, and type[2:0] is the VC.
  logic       dllp_ok;
  logic [1:0] dllp_cls;
  logic       is_init1;
  logic       is_init2;
  logic       is_update;

  assign dllp_cls  = bus.fc_dllp_type_i[5:4];
  assign dllp_ok   = bus.fc_dllp_valid_i && !bus.fc_dllp_type_i[3] &&
                     (bus.fc_dllp_type_i[2:0] == VC_SEL) && (dllp_cls != 2'd3);
  assign is_init1  = dllp_ok && (bus.fc_dllp_type_i[7:6] == 2'b01);
  assign is_init2  = dllp_ok && (bus.fc_dllp_type_i[7:6] == 2'b11);
  assign is_update = dllp_ok && (bus.fc_dllp_type_i[7:6] == 2'b10);

  // Credit check on registered limits/consumed counts; zero latency from the request fields.
  logic [1:0]           sel;
  logic [DATA_FC_W-1:0] req_d;
  logic [HDR_FC_W-1:0]  h_room;
  logic [DATA_FC_W-1:0] d_room;
  logic                 ok_h;
  logic                 ok_d;
  logic                 d_over;
  logic                 cls_bad;
  logic                 ready;
  logic                 xfer;

  assign cls_bad = (bus.tlp_req_class_i == 2'd3);
  assign sel     = cls_bad ? 2'd0 : bus.tlp_req_class_i;
  assign req_d   = bus.tlp_req_data_cred_i;
  assign h_room  = cl_h[sel] - cc_h[sel] - HDR_ONE;
  assign d_room  = cl_d[sel] - cc_d[sel] - req_d;
  assign ok_h    = inf_h[sel] || (h_room <= HDR_HALF);
  assign ok_d    = inf_d[sel] || (req_d == '0) || (d_room <= DATA_HALF);
  // A request larger than half the data window can never be judged safely, so it is never issued.
  assign d_over  = (req_d > DATA_HALF);
  assign ready   = (state == FC_ACTIVE) && !cls_bad && !d_over && ok_h && ok_d;
  assign xfer    = bus.tlp_req_valid_i && ready;

  assign bus.tlp_req_ready_o = ready;
  assign bus.fc_state_o      = state;
  assign bus.fc_init_done_o  = init_done_q;
  assign bus.fc_err_o        = err_q;

  // FC init FSM plus per-class limit and consumed-credit registers; link loss wipes everything.
  always_ff @(posedge sclk) begin
    if (sreset || !link_up_i) begin
      state       <= FC_IDLE;
      init_done_q <= 1'b0;
      seen        <= '0;
      inf_h       <= '0;
      inf_d       <= '0;
      for (int i = 0; i < 3; i++) begin
        cl_h[i] <= '0;
        cc_h[i] <= '0;
        cl_d[i] <= '0;
        cc_d[i] <= '0;
      end
    end else begin
      case (state)
        FC_IDLE: begin
          state <= FC_INIT1;
        end
        FC_INIT1: begin
          // Duplicate InitFC1s simply overwrite; a zero field advertises infinite credit.
          if (is_init1) begin
            cl_h[dllp_cls]  <= bus.fc_dllp_hdr_i;
            cl_d[dllp_cls]  <= bus.fc_dllp_data_i;
            inf_h[dllp_cls] <= (bus.fc_dllp_hdr_i == '0);
            inf_d[dllp_cls] <= (bus.fc_dllp_data_i == '0);
            seen[dllp_cls]  <= 1'b1;
          end
          if (seen == 3'b111) begin
            state <= FC_INIT2;
          end
        end
        FC_INIT2: begin
          if (is_init2 || is_update) begin
            state       <= FC_ACTIVE;
            init_done_q <= 1'b1;
          end
        end
        FC_ACTIVE: begin
          // Limits behind the consumed count are stored as-is; the modular check blocks issue.
          if (is_update) begin
            if (!inf_h[dllp_cls]) cl_h[dllp_cls] <= bus.fc_dllp_hdr_i;
            if (!inf_d[dllp_cls]) cl_d[dllp_cls] <= bus.fc_dllp_data_i;
          end
        end
        default: state <= FC_IDLE;
      endcase
      // Consumed counts are separate registers from limits, so a same-cycle UpdateFC also lands.
      if (xfer) begin
        cc_h[sel] <= cc_h[sel] + HDR_ONE;
        cc_d[sel] <= cc_d[sel] + req_d;
      end
    end
  end

  // One-cycle error pulse for requests that can never be granted.
  always_ff @(posedge sclk) begin
    if (sreset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= bus.tlp_req_valid_i && (cls_bad || d_over);
    end
  end

endmodule

// File: tb/tb_pcie_tx_fc_credit_gate.sv
// Directed bench for the VC0 TX flow-control credit gate.
module tb_pcie_tx_fc_credit_gate;

  logic sclk    = 1'b0;
  logic sreset  = 1'b1;
  logic link_up = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 sclk = ~sclk;

  pcie_tx_fc_credit_gate_if #(.HDR_FC_W(8), .DATA_FC_W(12)) bus ();

  pcie_tx_fc_credit_gate #(.HDR_FC_W(8), .DATA_FC_W(12), .VC_ID(0)) dut (
    .sclk      (sclk),
    .sreset    (sreset),
    .link_up_i (link_up),
    .bus       (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic send_dllp(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d);
    bus.fc_dllp_valid_i = 1'b1;
    bus.fc_dllp_type_i  = t;
    bus.fc_dllp_hdr_i   = h;
    bus.fc_dllp_data_i  = d;
    tick();
    bus.fc_dllp_valid_i = 1'b0;
  endtask

  // Present one request, check ready, hold it across one edge, then withdraw it.
  task automatic req(input logic [1:0] c, input logic [11:0] d, input logic exp, input string tag);
    bus.tlp_req_valid_i     = 1'b1;
    bus.tlp_req_class_i     = c;
    bus.tlp_req_data_cred_i = d;
    #1;
    check(tag, 32'(bus.tlp_req_ready_o), 32'(exp));
    tick();
    bus.tlp_req_valid_i = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] exp, input int budget, input string tag);
    int n = 0;
    while (bus.fc_state_o !== exp && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.fc_state_o), 32'(exp));
  endtask

  initial begin
    bus.fc_dllp_valid_i     = 1'b0;
    bus.fc_dllp_type_i      = 8'h00;
    bus.fc_dllp_hdr_i       = 8'h00;
    bus.fc_dllp_data_i      = 12'h000;
    bus.tlp_req_valid_i     = 1'b0;
    bus.tlp_req_class_i     = 2'd0;
    bus.tlp_req_data_cred_i = 12'h000;

    // Reset state
    repeat (3) tick();
    check("rst_state", 32'(bus.fc_state_o), 32'd0);
    check("rst_init_done", 32'(bus.fc_init_done_o), 32'd0);
    check("rst_err", 32'(bus.fc_err_o), 32'd0);
    req(2'd0, 12'd0, 1'b0, "rst_ready");
    sreset = 1'b0;
    tick();
    check("idle_link_down", 32'(bus.fc_state_o), 32'd0);

    // T1: init sequence
    link_up = 1'b1;
    tick();
    check("t1_init1", 32'(bus.fc_state_o), 32'd1);
    send_dllp(8'h40, 8'd4, 12'd16);
    send_dllp(8'h50, 8'd4, 12'd16);
    check("t1_init1_partial", 32'(bus.fc_state_o), 32'd1);
    send_dllp(8'h60, 8'd4, 12'd16);
    wait_state(2'd2, 4, "t1_init2");
    check("t1_not_done", 32'(bus.fc_init_done_o), 32'd0);
    req(2'd0, 12'd0, 1'b0, "t1_ready_init2");
    send_dllp(8'hC0, 8'd0, 12'd0);
    check("t1_active", 32'(bus.fc_state_o), 32'd3);
    check("t1_done", 32'(bus.fc_init_done_o), 32'd1);

    // T2: exhaust Posted credits (hdr 4, data 16)
    for (int i = 0; i < 4; i++) req(2'd0, 12'd4, 1'b1, "t2_p_grant");
    req(2'd0, 12'd4, 1'b0, "t2_p5_blocked");
    send_dllp(8'h80, 8'd5, 12'd20);
    req(2'd0, 12'd4, 1'b1, "t2_p5_granted");
    req(2'd0, 12'd0, 1'b0, "t2_p6_blocked");

    // T5: UpdateFC NP and NP grant on the same cycle
    for (int i = 0; i < 3; i++) req(2'd1, 12'd0, 1'b1, "t5_np_grant");
    bus.fc_dllp_valid_i = 1'b1;
    bus.fc_dllp_type_i  = 8'h90;
    bus.fc_dllp_hdr_i   = 8'd5;
    bus.fc_dllp_data_i  = 12'd16;
    req(2'd1, 12'd0, 1'b1, "t5_sim_grant");
    bus.fc_dllp_valid_i = 1'b0;
    req(2'd1, 12'd0, 1'b1, "t5_after_sim");
    req(2'd1, 12'd0, 1'b0, "t5_blocked");

    // T4 data: drive NP CC_D to 4090, then wrapped limit 4 leaves 10 credits
    send_dllp(8'h90, 8'd20, 12'd2045);
    req(2'd1, 12'd2045, 1'b1, "t4d_step1");
    send_dllp(8'h90, 8'd20, 12'd4090);
    req(2'd1, 12'd2045, 1'b1, "t4d_step2");
    send_dllp(8'h90, 8'd20, 12'd4);
    req(2'd1, 12'd11, 1'b0, "t4d_11_blocked");
    req(2'd1, 12'd10, 1'b1, "t4d_10_granted");
    req(2'd1, 12'd1, 1'b0, "t4d_full");

    // Error pulses (Posted is header-blocked here)
    req(2'd3, 12'd0, 1'b0, "err_cls3_ready");
    check("err_cls3_pulse", 32'(bus.fc_err_o), 32'd1);
    tick();
    check("err_cls3_clear", 32'(bus.fc_err_o), 32'd0);
    req(2'd0, 12'd2048, 1'b0, "err_d2048_ready");
    check("err_d2048_none", 32'(bus.fc_err_o), 32'd0);
    req(2'd0, 12'd2049, 1'b0, "err_d2049_ready");
    check("err_d2049_pulse", 32'(bus.fc_err_o), 32'd1);
    tick();
    check("err_d2049_clear", 32'(bus.fc_err_o), 32'd0);

    // T4 header: Cpl CC_H walks to 250, limit 3 wraps, 9 more grants
    for (int i = 0; i < 4; i++) req(2'd2, 12'd0, 1'b1, "t4h_a");
    send_dllp(8'hA0, 8'd130, 12'd16);
    for (int i = 0; i < 126; i++) req(2'd2, 12'd0, 1'b1, "t4h_b");
    send_dllp(8'hA0, 8'd250, 12'd16);
    for (int i = 0; i < 120; i++) req(2'd2, 12'd0, 1'b1, "t4h_c");
    send_dllp(8'hA0, 8'd3, 12'd16);
    for (int i = 0; i < 9; i++) req(2'd2, 12'd0, 1'b1, "t4h_wrap");
    req(2'd2, 12'd0, 1'b0, "t4h_10th_blocked");

    // T6: link drop mid-stream
    req(2'd1, 12'd0, 1'b1, "t6_np_before_drop");
    link_up = 1'b0;
    tick();
    check("t6_state_idle", 32'(bus.fc_state_o), 32'd0);
    check("t6_done_clear", 32'(bus.fc_init_done_o), 32'd0);
    req(2'd1, 12'd0, 1'b0, "t6_ready_after_drop");

    // Re-init: P duplicate overwrite, NP infinite data, Cpl infinite both
    link_up = 1'b1;
    tick();
    check("t6_reinit1", 32'(bus.fc_state_o), 32'd1);
    send_dllp(8'h40, 8'd9, 12'd9);
    send_dllp(8'h40, 8'd2, 12'd2);
    send_dllp(8'h50, 8'd1, 12'd0);
    send_dllp(8'h60, 8'd0, 12'd0);
    wait_state(2'd2, 4, "t6_reinit2");
    send_dllp(8'hD0, 8'd0, 12'd0);
    check("t6_reactive", 32'(bus.fc_state_o), 32'd3);
    req(2'd0, 12'd1, 1'b1, "t6_p_cc_cleared_1");
    req(2'd0, 12'd1, 1'b1, "t6_p_cc_cleared_2");
    req(2'd0, 12'd1, 1'b0, "t6_p_overwrite_blocked");
    send_dllp(8'h81, 8'd50, 12'd50);
    req(2'd0, 12'd1, 1'b0, "vc1_ignored");
    send_dllp(8'h80, 8'd3, 12'd3);
    req(2'd0, 12'd1, 1'b1, "vc0_update");
    req(2'd1, 12'd2000, 1'b1, "np_inf_data");
    req(2'd1, 12'd0, 1'b0, "np_hdr_exhaust");

    // T3: infinite Cpl credits
    for (int i = 0; i < 300; i++) req(2'd2, 12'd8, 1'b1, "t3_cpl_inf");
    send_dllp(8'hA0, 8'd1, 12'd1);
    req(2'd2, 12'd8, 1'b1, "t3_update_ignored");

    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
